// File: rtl/ins_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding fetch at a time into a small
// FIFO of {instruction, PC} entries, with flush-and-restart support.
module ins_prefetch_queue #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] flush_target_PC,
    output logic        try_start_insfetch_task,
    output logic [31:0] insfetch_addr,
    input  logic        insfetch_task_accepted,
    input  logic        insfetch_task_done,
    input  logic [31:0] insfetch_ins_full,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] ins_PC,
    input  logic        ins_take
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              try_start_q, try_start_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    entry_t            mem_q [DEPTH];

    logic              push;
    logic              pop;
    entry_t            entry_new;
    entry_t            entry_head;

    // Fetch FSM, FIFO pointer update and next head presentation
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        try_start_d = try_start_q;
        addr_d      = addr_q;
        push        = 1'b0;
        pop         = 1'b0;
        entry_new   = '{ins: insfetch_ins_full, pc: fetch_pc_q};
        entry_head  = mem_q[head_q];

        unique case (state_q)
            S_IDLE: begin
                if (!flush_pipline && (count_q < CNT_W'(DEPTH))) begin
                    state_d     = S_WAIT_ACCEPT;
                    try_start_d = 1'b1;
                    addr_d      = fetch_pc_q;
                end
            end
            S_WAIT_ACCEPT: begin
                if (insfetch_task_accepted) begin
                    try_start_d = 1'b0;
                    state_d     = flush_pipline ? S_DRAIN : S_WAIT_DONE;
                end else if (flush_pipline) begin
                    try_start_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (flush_pipline) begin
                    state_d = insfetch_task_done ? S_IDLE : S_DRAIN;
                end else if (insfetch_task_done) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (insfetch_task_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop = ins_take && (count_q != '0) && !flush_pipline;

        if (flush_pipline) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            fetch_pc_d  = flush_target_PC;
            try_start_d = 1'b0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // The freshly pushed word becomes the head when nothing older remains
        valid_d    = (count_d != '0);
        entry_head = (push && (head_d == tail_q)) ? entry_new : mem_q[head_d];
        out_d      = valid_d ? entry_head.ins : '0;
        pc_out_d   = valid_d ? entry_head.pc  : '0;
    end

    // Control and output registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            try_start_q <= 1'b0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            out_q       <= '0;
            pc_out_q    <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            try_start_q <= try_start_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
            pc_out_q    <= pc_out_d;
        end
    end

    // Entry storage needs no reset: only entries below count are ever shown
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            mem_q[tail_q] <= entry_new;
        end
    end

    assign try_start_insfetch_task = try_start_q;
    assign insfetch_addr           = addr_q;
    assign ins_valid               = valid_q;
    assign ins_out                 = out_q;
    assign ins_PC                  = pc_out_q;

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Directed bench for ins_prefetch_queue: the bench plays the memory adapter and
// issue stage, checking every observation against hand-computed values.
module tb_ins_prefetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic [31:0] flush_target_PC;
    logic        try_start_insfetch_task;
    logic [31:0] insfetch_addr;
    logic        insfetch_task_accepted;
    logic        insfetch_task_done;
    logic [31:0] insfetch_ins_full;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_PC;
    logic        ins_take;

    int errors = 0;
    int checks = 0;

    ins_prefetch_queue #(.DEPTH_LOG2(2), .RESET_PC(32'h0)) dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        .flush_pipline           (flush_pipline),
        .flush_target_PC         (flush_target_PC),
        .try_start_insfetch_task (try_start_insfetch_task),
        .insfetch_addr           (insfetch_addr),
        .insfetch_task_accepted  (insfetch_task_accepted),
        .insfetch_task_done      (insfetch_task_done),
        .insfetch_ins_full       (insfetch_ins_full),
        .ins_valid               (ins_valid),
        .ins_out                 (ins_out),
        .ins_PC                  (ins_PC),
        .ins_take                (ins_take)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (try_start_insfetch_task !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_timeout", 32'(try_start_insfetch_task), 32'd1);
    endtask

    // Adapter: accept in one cycle, done two cycles after the accept edge
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word, input logic take_at_done);
        wait_req();
        chk("req_addr", insfetch_addr, exp_addr);
        insfetch_task_accepted = 1'b1;
        step();
        insfetch_task_accepted = 1'b0;
        chk("try_low_after_accept", 32'(try_start_insfetch_task), 32'd0);
        step();
        insfetch_task_done = 1'b1;
        insfetch_ins_full  = word;
        ins_take           = take_at_done;
        step();
        insfetch_task_done = 1'b0;
        insfetch_ins_full  = 32'h0;
        ins_take           = 1'b0;
    endtask

    function automatic logic [31:0] wrd(input logic [31:0] pc);
        return 32'hA000_0000 + pc;
    endfunction

    initial begin
        rst_in                 = 1'b1;
        rdy_in                 = 1'b1;
        flush_pipline          = 1'b0;
        flush_target_PC        = 32'h0;
        insfetch_task_accepted = 1'b0;
        insfetch_task_done     = 1'b0;
        insfetch_ins_full      = 32'h0;
        ins_take               = 1'b0;

        #2;
        chk("rst_try", 32'(try_start_insfetch_task), 32'd0);
        chk("rst_addr", insfetch_addr, 32'h0);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_out", ins_out, 32'h0);
        chk("rst_pc", ins_PC, 32'h0);
        step();
        step();
        rst_in = 1'b0;

        // T1: first fetch from RESET_PC
        serve(32'h0, 32'h0000_0013, 1'b0);
        chk("t1_valid", 32'(ins_valid), 32'd1);
        chk("t1_pc", ins_PC, 32'h0);
        chk("t1_out", ins_out, 32'h13);

        // T2: fill to four entries, then credit stalls requests
        serve(32'h4, wrd(32'h4), 1'b0);
        serve(32'h8, wrd(32'h8), 1'b0);
        serve(32'hC, wrd(32'hC), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_full_no_req", 32'(try_start_insfetch_task), 32'd0);
        end
        chk("t2_head_pc", ins_PC, 32'h0);
        ins_take = 1'b1;
        step();
        ins_take = 1'b0;
        chk("t2_pop_pc", ins_PC, 32'h4);
        chk("t2_pop_out", ins_out, wrd(32'h4));

        // T3: push and pop on the same edge, pointers wrap
        for (int k = 0; k < 4; k++) begin
            serve(32'h10 + 32'(4 * k), wrd(32'h10 + 32'(4 * k)), 1'b1);
            chk("t3_valid", 32'(ins_valid), 32'd1);
            chk("t3_head_pc", ins_PC, 32'h8 + 32'(4 * k));
            chk("t3_head_out", ins_out, wrd(32'h8 + 32'(4 * k)));
        end

        // T4: flush in WAIT_DONE, late done is dropped
        wait_req();
        chk("t4_addr", insfetch_addr, 32'h20);
        insfetch_task_accepted = 1'b1;
        step();
        insfetch_task_accepted = 1'b0;
        flush_pipline   = 1'b1;
        flush_target_PC = 32'h100;
        step();
        flush_pipline   = 1'b0;
        chk("t4_valid", 32'(ins_valid), 32'd0);
        chk("t4_out", ins_out, 32'h0);
        chk("t4_pc", ins_PC, 32'h0);
        chk("t4_try", 32'(try_start_insfetch_task), 32'd0);
        step();
        chk("t4_drain_try", 32'(try_start_insfetch_task), 32'd0);
        insfetch_task_done = 1'b1;
        insfetch_ins_full  = 32'hDEAD_BEEF;
        step();
        insfetch_task_done = 1'b0;
        insfetch_ins_full  = 32'h0;
        chk("t4_dropped", 32'(ins_valid), 32'd0);
        step();
        chk("t4_new_req", 32'(try_start_insfetch_task), 32'd1);
        chk("t4_new_addr", insfetch_addr, 32'h100);
        serve(32'h100, wrd(32'h100), 1'b0);
        chk("t4_first_valid", 32'(ins_valid), 32'd1);
        chk("t4_first_pc", ins_PC, 32'h100);

        // T5: flush in WAIT_ACCEPT without accept withdraws the request
        wait_req();
        chk("t5_addr", insfetch_addr, 32'h104);
        flush_pipline   = 1'b1;
        flush_target_PC = 32'h200;
        step();
        flush_pipline   = 1'b0;
        chk("t5_try_fall", 32'(try_start_insfetch_task), 32'd0);
        chk("t5_valid", 32'(ins_valid), 32'd0);
        step();
        chk("t5_req_next", 32'(try_start_insfetch_task), 32'd1);
        chk("t5_addr_next", insfetch_addr, 32'h200);
        serve(32'h200, wrd(32'h200), 1'b0);
        chk("t5_head_pc", ins_PC, 32'h200);

        // T6: stall mid-WAIT_DONE with done and take asserted
        wait_req();
        chk("t6_addr", insfetch_addr, 32'h204);
        insfetch_task_accepted = 1'b1;
        step();
        insfetch_task_accepted = 1'b0;
        rdy_in             = 1'b0;
        insfetch_task_done = 1'b1;
        insfetch_ins_full  = 32'hBAD0_0BAD;
        ins_take           = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_stall_try", 32'(try_start_insfetch_task), 32'd0);
            chk("t6_stall_addr", insfetch_addr, 32'h204);
            chk("t6_stall_valid", 32'(ins_valid), 32'd1);
            chk("t6_stall_pc", ins_PC, 32'h200);
            chk("t6_stall_out", ins_out, wrd(32'h200));
        end
        rdy_in             = 1'b1;
        insfetch_task_done = 1'b1;
        insfetch_ins_full  = wrd(32'h204);
        ins_take           = 1'b0;
        step();
        insfetch_task_done = 1'b0;
        insfetch_ins_full  = 32'h0;
        chk("t6_after_pc", ins_PC, 32'h200);
        ins_take = 1'b1;
        step();
        ins_take = 1'b0;
        chk("t6_pop_pc", ins_PC, 32'h204);
        chk("t6_pop_out", ins_out, wrd(32'h204));
        chk("t6_req", 32'(try_start_insfetch_task), 32'd1);
        chk("t6_req_addr", insfetch_addr, 32'h208);
        insfetch_task_accepted = 1'b1;
        step();
        insfetch_task_accepted = 1'b0;

        // Asynchronous reset between clock edges
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_arst_try", 32'(try_start_insfetch_task), 32'd0);
        chk("t6_arst_addr", insfetch_addr, 32'h0);
        chk("t6_arst_valid", 32'(ins_valid), 32'd0);
        chk("t6_arst_out", ins_out, 32'h0);
        chk("t6_arst_pc", ins_PC, 32'h0);
        step();
        rst_in = 1'b0;
        step();
        chk("t6_restart_req", 32'(try_start_insfetch_task), 32'd1);
        chk("t6_restart_addr", insfetch_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
